// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module   : reorder_buffer
// Purpose  : In-order retirement buffer with writeback marking, branch flush
//            and free-list deallocation of the previous physical mapping.
// Revision : 1.0
// ============================================================================
module reorder_buffer #(
  parameter int ROB_DEPTH     = 16,
  parameter int TAG_BITS      = 4,
  parameter int PHYS_REG_BITS = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alloc_valid,
  input  logic                     alloc_has_dest,
  input  logic [4:0]               alloc_areg,
  input  logic [PHYS_REG_BITS-1:0] alloc_preg,
  input  logic [PHYS_REG_BITS-1:0] alloc_old_preg,
  output logic                     alloc_ready,
  output logic [TAG_BITS-1:0]      alloc_tag,
  input  logic                     wb_valid,
  input  logic [TAG_BITS-1:0]      wb_tag,
  output logic                     commit_valid,
  output logic [4:0]               commit_areg,
  output logic [PHYS_REG_BITS-1:0] commit_preg,
  output logic                     dealloc_en,
  output logic [PHYS_REG_BITS-1:0] dealloc_preg,
  input  logic                     flush_en,
  input  logic [TAG_BITS-1:0]      flush_tag,
  output logic                     empty,
  output logic                     full,
  output logic [TAG_BITS:0]        count
);

  localparam logic [TAG_BITS:0] c_PTR_ONE = 1;

  logic [TAG_BITS:0]          r_head;
  logic [TAG_BITS:0]          r_tail;
  logic [ROB_DEPTH-1:0]       r_valid;
  logic [ROB_DEPTH-1:0]       r_done;
  logic [ROB_DEPTH-1:0]       r_has_dest;
  logic [4:0]                 r_areg     [ROB_DEPTH];
  logic [PHYS_REG_BITS-1:0]   r_preg     [ROB_DEPTH];
  logic [PHYS_REG_BITS-1:0]   r_old_preg [ROB_DEPTH];

  logic [TAG_BITS-1:0]        w_head_idx;
  logic [TAG_BITS-1:0]        w_tail_idx;
  logic [TAG_BITS-1:0]        w_flush_off;
  logic [TAG_BITS-1:0]        w_wb_off;
  logic                       w_commit;
  logic                       w_flush;
  logic                       w_wb_ok;
  logic                       w_alloc;
  logic [ROB_DEPTH-1:0]       w_squash;

  assign w_head_idx = r_head[TAG_BITS-1:0];
  assign w_tail_idx = r_tail[TAG_BITS-1:0];

  assign empty       = (r_head == r_tail);
  assign full        = (w_head_idx == w_tail_idx) && (r_head[TAG_BITS] != r_tail[TAG_BITS]);
  assign count       = r_tail - r_head;
  assign alloc_ready = !full;
  assign alloc_tag   = w_tail_idx;

  assign w_commit = r_valid[w_head_idx] && r_done[w_head_idx] && !empty;

  assign commit_valid = w_commit;
  assign commit_areg  = w_commit ? r_areg[w_head_idx] : 5'd0;
  assign commit_preg  = w_commit ? r_preg[w_head_idx] : '0;
  assign dealloc_en   = w_commit && r_has_dest[w_head_idx];
  assign dealloc_preg = w_commit ? r_old_preg[w_head_idx] : '0;

  // Age is measured as distance from head, so comparisons survive wraparound.
  assign w_flush     = flush_en && r_valid[flush_tag];
  assign w_flush_off = flush_tag - w_head_idx;
  assign w_wb_off    = wb_tag - w_head_idx;
  assign w_wb_ok     = wb_valid && r_valid[wb_tag] && (!w_flush || (w_wb_off <= w_flush_off));
  assign w_alloc     = alloc_valid && !full && !flush_en;

  generate
    for (genvar gi = 0; gi < ROB_DEPTH; gi++) begin : g_squash
      logic [TAG_BITS-1:0] w_entry_off;
      assign w_entry_off  = TAG_BITS'(gi) - w_head_idx;
      assign w_squash[gi] = w_flush && (w_entry_off > w_flush_off);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_valid <= '0;
      r_done  <= '0;
    end else begin
      r_valid <= r_valid & ~w_squash;
      if (w_commit) begin
        r_valid[w_head_idx] <= 1'b0;
        r_head              <= r_head + c_PTR_ONE;
      end
      if (w_wb_ok) begin
        r_done[wb_tag] <= 1'b1;
      end
      if (w_alloc) begin
        r_valid[w_tail_idx] <= 1'b1;
        r_done[w_tail_idx]  <= 1'b0;
      end
      // New tail sits just past the kept branch; wrap bit follows from head.
      if (w_flush) begin
        r_tail <= r_head + {1'b0, w_flush_off} + c_PTR_ONE;
      end else if (w_alloc) begin
        r_tail <= r_tail + c_PTR_ONE;
      end
    end
  end

  // Payload fields are only meaningful while valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_alloc && !rst) begin
      r_has_dest[w_tail_idx] <= alloc_has_dest;
      r_areg[w_tail_idx]     <= alloc_areg;
      r_preg[w_tail_idx]     <= alloc_preg;
      r_old_preg[w_tail_idx] <= alloc_old_preg;
    end
  end

endmodule
`default_nettype wire

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameters: ROB_DEPTH, default 16, entry count (power of 2); TAG_BITS, default 4, log2(ROB_DEPTH); PHYS_REG_BITS, default 7, from ooo_types.
REQ-002 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port alloc_valid  in  1  dispatch request for one instruction.
REQ-005 SHALL have port alloc_has_dest  in  1  instruction writes an architectural register.
REQ-006 SHALL have port alloc_areg  in  5  destination architectural register.
REQ-007 SHALL have port alloc_preg  in  PHYS_REG_BITS  newly allocated physical register.
REQ-008 SHALL have port alloc_old_preg  in  PHYS_REG_BITS  previous mapping of alloc_areg, freed at commit.
REQ-009 SHALL have port alloc_ready  out  1  entry available, equal to !full.
REQ-010 SHALL have port alloc_tag  out  TAG_BITS  index the next accepted allocation receives (tail index).
REQ-011 SHALL have port wb_valid  in  1  execution completion; wb_tag  in  TAG_BITS  completing entry.
REQ-012 SHALL have port commit_valid  out  1; commit_areg  out  5; commit_preg  out  PHYS_REG_BITS.
REQ-013 SHALL have port dealloc_en  out  1; dealloc_preg  out  PHYS_REG_BITS; these drive the free list's deallocation port.
REQ-014 SHALL have port flush_en  in  1; flush_tag  in  TAG_BITS  mispredicted branch entry, which is kept while all younger entries are squashed.
REQ-015 SHALL have port empty  out  1; full  out  1; count  out  TAG_BITS+1.

Function
REQ-016 SHALL hold a circular buffer whose entries contain valid, done, has_dest, areg, preg and old_preg.
REQ-017 SHALL keep head and tail pointers of TAG_BITS+1 bits, with the MSB used as a wrap bit.
REQ-018 SHALL compute empty as (head == tail), full as index equal with wrap bit differing, and count as tail - head modulo 2^(TAG_BITS+1).
REQ-019 SHALL accept an allocation when alloc_valid && !full && !flush_en, writing the entry at tail with done=0 and valid=1 and incrementing tail.
REQ-020 SHALL ignore alloc_valid when full, with no state change and no error.
REQ-021 SHALL set done on wb_valid for entry wb_tag only if that entry is valid; writebacks to invalid entries SHALL be ignored.
REQ-022 SHALL compute commit_valid combinationally as head entry valid && done && !empty, and SHALL retire at most one entry per cycle.
REQ-023 SHALL, on commit, clear the head entry's valid bit and increment head at the clock edge.
REQ-024 SHALL drive dealloc_en = commit_valid && head.has_dest and dealloc_preg = head.old_preg, both in the same cycle as commit_valid.
REQ-025 SHALL keep commit and dealloc outputs zero when commit_valid = 0.
REQ-026 SHALL allow a writeback to the head entry to commit no earlier than the next cycle (latency 1).
REQ-027 SHALL, on flush_en with flush_tag valid, clear valid on every entry younger than flush_tag and set tail to flush_tag + 1 with the wrap bit derived from head.
REQ-028 SHALL ignore flush_en when flush_tag is not a valid entry.
REQ-029 SHALL, when flush and commit occur in the same cycle, perform the commit, so count_next = flush_tag - head + 1 - 1.
REQ-030 SHALL, when flush and allocation occur in the same cycle, let the flush win and drop the allocation.
REQ-031 SHALL, when flush and writeback occur in the same cycle, set done only if wb_tag survives the flush.
REQ-032 SHALL support allocation and commit in the same cycle; when full, alloc_ready stays 0 that cycle because it is based on registered state (no bypass).
REQ-033 SHALL wrap pointers from index ROB_DEPTH-1 to 0 and toggle the wrap bit.

Reset
REQ-034 SHALL, with rst high at a clock edge, set head = tail = 0, clear all valid and done bits, set empty=1, full=0, count=0, alloc_ready=1, alloc_tag=0, and drive commit_valid=0 and dealloc_en=0.
REQ-035 SHALL let rst override flush_en, alloc_valid and wb_valid in the same cycle, discarding in-flight entries.

Verification
REQ-036 SHALL cover: reset → empty=1, count=0, alloc_tag=0, commit_valid=0.
REQ-037 SHALL cover: allocate 3 entries (old_preg 32, 33, 34; has_dest=1); writeback tags 2, 1, 0 in order → no commit until tag 0 is done, then dealloc_preg = 32, 33, 34 on consecutive cycles.
REQ-038 SHALL cover: 16 allocations → full=1, alloc_ready=0; a 17th alloc_valid is ignored (count stays 16); simultaneous commit and alloc when count=15 → count stays 15.
REQ-039 SHALL cover: allocate 6 entries, flush_tag=2 → count=3, alloc_tag=3; a later writeback to tag 4 is ignored.
REQ-040 SHALL cover: 20 allocate-then-commit cycles → alloc_tag wraps to 4, wrap bit toggled, empty=1 after the final commit.
REQ-041 SHALL cover: head done with has_dest=0 → commit_valid=1, dealloc_en=0; rst asserted with 5 entries valid → empty=1 on the next cycle.
